// File: rtl/demux16to48_buf.sv
// Routes one input word per cycle into one of four single-entry output slots chosen by {dr,control}; latency 1.
// in_ready drops when orf is low or the selected slot is full and not acked in the same cycle.
module demux16to48_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             orf,
  input  logic             dr,
  input  logic             control,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ack,
  output logic [15:0]      xfer_count
);

  logic [1:0]       sel;
  logic             accept;
  logic [WIDTH-1:0] slot_dat [4];

  assign sel      = {dr, control};
  // A full slot can take a new word in the same cycle its current word is acked.
  assign in_ready = orf & (~out_valid[sel] | out_ack[sel]);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        slot_dat[i] <= '0;
      end
      out_valid  <= 4'b0000;
      xfer_count <= 16'h0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (sel == 2'(i))) begin
          slot_dat[i]  <= in;
          out_valid[i] <= 1'b1;
        end else if (out_ack[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
      if (accept) begin
        xfer_count <= xfer_count + 16'd1;
      end
    end
  end

  assign out1 = slot_dat[0];
  assign out2 = slot_dat[1];
  assign out3 = slot_dat[2];
  assign out4 = slot_dat[3];

endmodule

// File: tb/tb_demux16to48_buf.sv
// Directed bench for demux16to48_buf: a reference model pushes expected slot state
// into a queue each cycle, which is popped and compared one cycle later.
module tb_demux16to48_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        in_valid;
  logic        in_ready;
  logic        orf;
  logic        dr;
  logic        control;
  logic [31:0] out1, out2, out3, out4;
  logic [3:0]  out_valid;
  logic [3:0]  out_ack;
  logic [15:0] xfer_count;

  typedef struct packed {
    logic [3:0][31:0] d;
    logic [3:0]       v;
    logic [15:0]      c;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_dat [4];
  logic [3:0]  m_vld;
  logic [15:0] m_cnt;
  int          n_assert = 0;
  int          n_fail   = 0;

  demux16to48_buf #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .orf(orf), .dr(dr), .control(control),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .out_valid(out_valid), .out_ack(out_ack), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_dat[i] = '0;
    m_vld = '0;
    m_cnt = '0;
  endtask

  // Drive one cycle, check in_ready, advance the model, then check registered outputs.
  task automatic step(input logic v, input logic o, input logic [1:0] s, input logic [31:0] d,
                      input logic [3:0] ack, input logic r, input string tag);
    logic exp_rdy;
    logic acc;
    exp_t e;
    exp_t got;
    in_valid = v; orf = o; {dr, control} = s; din = d; out_ack = ack; reset = r;
    #1;
    exp_rdy = o & (~m_vld[s] | ack[s]);
    chk({tag, "_rdy"}, {63'd0, in_ready}, {63'd0, exp_rdy});
    if (r) begin
      model_clear();
    end else begin
      acc = v & exp_rdy;
      for (int i = 0; i < 4; i++) begin
        if (acc && s == 2'(i)) begin
          m_dat[i] = d;
          m_vld[i] = 1'b1;
        end else if (ack[i]) begin
          m_vld[i] = 1'b0;
        end
      end
      if (acc) m_cnt = m_cnt + 16'd1;
    end
    for (int i = 0; i < 4; i++) e.d[i] = m_dat[i];
    e.v = m_vld;
    e.c = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      got.d[0] = out1; got.d[1] = out2; got.d[2] = out3; got.d[3] = out4;
      chk({tag, "_out1"}, {32'd0, got.d[0]}, {32'd0, e.d[0]});
      chk({tag, "_out2"}, {32'd0, got.d[1]}, {32'd0, e.d[1]});
      chk({tag, "_out3"}, {32'd0, got.d[2]}, {32'd0, e.d[2]});
      chk({tag, "_out4"}, {32'd0, got.d[3]}, {32'd0, e.d[3]});
      chk({tag, "_vld"}, {60'd0, out_valid}, {60'd0, e.v});
      chk({tag, "_cnt"}, {48'd0, xfer_count}, {48'd0, e.c});
    end
  endtask

  initial begin
    model_clear();
    reset = 1'b1; din = '0; in_valid = 1'b0; orf = 1'b0; dr = 1'b0; control = 1'b0; out_ack = '0;

    step(0, 0, 2'b00, 32'h0, 4'b0000, 1, "rst");
    step(1, 1, 2'b10, 32'hDEADBEEF, 4'b0000, 0, "single_sel10");
    step(0, 1, 2'b10, 32'h0, 4'b0000, 0, "single_hold");

    step(0, 0, 2'b00, 32'h0, 4'b0000, 1, "rst2");
    step(1, 1, 2'b00, 32'h1, 4'b0000, 0, "fill_out1");
    step(1, 1, 2'b00, 32'h2, 4'b0000, 0, "full_block");
    step(1, 1, 2'b00, 32'h2, 4'b0001, 0, "pass_through");

    step(0, 0, 2'b00, 32'h0, 4'b0000, 1, "rst3");
    for (int s = 0; s < 4; s++) begin
      step(1, 0, 2'(s), 32'h100 + 32'(s), 4'b0000, 0, "orf_off");
    end

    for (int s = 0; s < 4; s++) begin
      step(1, 1, 2'(s), 32'hC0DE0000 + 32'(s), 4'b0000, 0, "fill_all");
    end
    step(1, 1, 2'b01, 32'hBAD0BAD0, 4'b0000, 0, "full_sel01_blocked");
    step(0, 1, 2'b00, 32'h0, 4'b1111, 0, "ack_all");
    step(0, 1, 2'b00, 32'h0, 4'b1111, 0, "ack_empty");

    // Accept into slot 2 while acking slots 0 and 1 in the same cycle.
    step(1, 1, 2'b00, 32'h11111111, 4'b0000, 0, "fill_s0");
    step(1, 1, 2'b01, 32'h22222222, 4'b0000, 0, "fill_s1");
    step(1, 1, 2'b10, 32'h33333333, 4'b0011, 0, "acc_s2_ack_s01");
    step(1, 1, 2'b11, 32'h44444444, 4'b1100, 0, "acc_s3_ack_s2");

    step(1, 1, 2'b11, 32'hA5A5A5A5, 4'b0000, 1, "rst_beats_accept");
    step(0, 1, 2'b11, 32'h0, 4'b0000, 0, "after_rst");

    // Counter wrap: 65537 back-to-back accepts into slot 0 with its ack held high.
    step(0, 0, 2'b00, 32'h0, 4'b0000, 1, "rst4");
    in_valid = 1'b1; orf = 1'b1; {dr, control} = 2'b00; out_ack = 4'b0001; reset = 1'b0;
    for (int k = 0; k < 65537; k++) begin
      din = 32'(k);
      @(posedge clk);
      #1;
    end
    m_cnt    = m_cnt + 16'd1;
    m_dat[0] = 32'd65536;
    m_vld[0] = 1'b1;
    step(0, 1, 2'b00, 32'h0, 4'b0000, 0, "wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
